ads886x_multi_reader: RTL

//  Parametrised successor ADC front-end for ADS886x-class SAR ADCs in 3-wire mode (DIN tied high).

---
 rtl/ads886x_pkg.sv | 12 +
 rtl/ads886x_lane.sv | 18 +
 rtl/ads886x_multi_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ads886x_pkg.sv
// Shared types and timing helper for the ADS886x multi-lane reader.
package ads886x_pkg;

   typedef enum logic [1:0] {IDLE, CONV, READ, TAIL} state_t;

   // Clock edges from the trigger edge to out_valid rising.
   function automatic int unsigned lat(input int unsigned conv, input int unsigned bits,
                                       input int unsigned div, input int unsigned tail);
      return conv + 2 * div * bits + tail + 1;
   endfunction

endpackage

// File: rtl/ads886x_lane.sv
// One ADC lane: MSB-first serial capture into a parallel word.
module ads886x_lane #(
   parameter int unsigned BITS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic            din,
   output logic [BITS-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (en)    q <= {q[BITS-2:0], din};
   end

endmodule

// File: rtl/ads886x_multi_reader.sv
// Shared CS/SCLK sequencer for NCH parallel ADS886x ADCs in 3-wire mode,
// with single-shot/auto triggering and a valid/ready result register.
module ads886x_multi_reader
   import ads886x_pkg::*;
#(
   parameter int unsigned NCH         = 2,
   parameter int unsigned BITS        = 16,
   parameter int unsigned CONV_CYCLES = 47,
   parameter int unsigned SCLK_DIV    = 2,
   parameter int unsigned TAIL_CYCLES = 3,
   parameter int unsigned PERIOD_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                auto_en,
   input  logic [PERIOD_W-1:0] auto_period,
   input  logic [NCH-1:0]      dout,
   output logic                cs,
   output logic                sclk,
   output logic                din,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NCH*BITS-1:0] out_data,
   output logic [7:0]          out_seq,
   output logic                overrun,
   input  logic                clr_ovr
);

   localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
   localparam int unsigned HALF_W = $clog2(SCLK_DIV + 1);
   localparam int unsigned BIT_W  = $clog2(BITS + 1);
   localparam int unsigned TAIL_W = $clog2(TAIL_CYCLES + 1);
   localparam int unsigned DATA_W = NCH * BITS;

   state_t              state;
   logic [CONV_W-1:0]   conv_cnt;
   logic [HALF_W-1:0]   half_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [TAIL_W-1:0]   tail_cnt;
   logic                lead;
   logic [PERIOD_W-1:0] period_cnt;
   logic [DATA_W-1:0]   lane_q;
   logic                trig_go;
   logic                sample;
   logic                load;

   assign din     = 1'b1;
   assign trig_go = (state == IDLE) && (start || (auto_en && (period_cnt >= auto_period)));
   assign sample  = (state == READ) && !lead && sclk && (half_cnt == HALF_W'(SCLK_DIV - 1));
   assign load    = (state == TAIL) && (tail_cnt == TAIL_W'(TAIL_CYCLES - 1));

   // Sequencer; READ opens with one sclk-low setup cycle after CS falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cs       <= 1'b1;
         sclk     <= 1'b0;
         busy     <= 1'b0;
         conv_cnt <= '0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         tail_cnt <= '0;
         lead     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cs   <= 1'b1;
               sclk <= 1'b0;
               if (trig_go) begin
                  state    <= CONV;
                  busy     <= 1'b1;
                  conv_cnt <= '0;
               end
            end
            CONV: begin
               if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                  state    <= READ;
                  cs       <= 1'b0;
                  lead     <= 1'b1;
                  half_cnt <= '0;
                  bit_cnt  <= '0;
               end else begin
                  conv_cnt <= conv_cnt + CONV_W'(1);
               end
            end
            READ: begin
               if (lead) begin
                  lead <= 1'b0;
                  sclk <= 1'b1;
               end else if (half_cnt != HALF_W'(SCLK_DIV - 1)) begin
                  half_cnt <= half_cnt + HALF_W'(1);
               end else begin
                  half_cnt <= '0;
                  if (sclk) begin
                     sclk    <= 1'b0;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end else if (bit_cnt == BIT_W'(BITS)) begin
                     state    <= TAIL;
                     tail_cnt <= '0;
                  end else begin
                     sclk <= 1'b1;
                  end
               end
            end
            TAIL: begin
               if (load) begin
                  state <= IDLE;
                  cs    <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  tail_cnt <= tail_cnt + TAIL_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Start-to-start spacing counter for auto mode; saturates.
   always_ff @(posedge clk) begin
      if (rst)                  period_cnt <= '0;
      else if (trig_go)         period_cnt <= PERIOD_W'(1);
      else if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_W'(1);
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      ads886x_lane #(.BITS(BITS)) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (trig_go),
         .en  (sample),
         .din (dout[k]),
         .q   (lane_q[k*BITS +: BITS])
      );
   end

   // Result register; a landing result beats an accept, overrun set beats clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_seq   <= '0;
         overrun   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= lane_q;
         out_seq   <= out_seq + 8'd1;
         if (out_valid && !out_ready) overrun <= 1'b1;
         else if (clr_ovr)            overrun <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (clr_ovr)                overrun   <= 1'b0;
      end
   end

endmodule
